lt24_frame_scheduler: RTL and testbench

//  Sequences the LT24 display pipeline: owns the raster scan counters (xAddr/yAddr),

---
 rtl/lt24_sched_pkg.sv | 51 +++++
 rtl/lt24_scan_counter.sv | 59 +++++
 rtl/lt24_frame_scheduler.sv | 121 ++++++++++++
 tb/tb_lt24_frame_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt24_sched_pkg.sv
// Shared encodings for the LT24 frame scheduler: screen phases, game outcome codes
// and the layer-enable bundle that the pixel mux consumes.
package lt24_sched_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_SPLASH  = 3'd1,
    PH_CREDITS = 3'd2,
    PH_GAME    = 3'd3,
    PH_OVER    = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    GS_PLAY = 2'b00,
    GS_XWIN = 2'b01,
    GS_OWIN = 2'b10,
    GS_DRAW = 2'b11
  } game_state_e;

  typedef struct packed {
    logic text;
    logic cursor;
    logic board;
  } layer_en_t;

  function automatic layer_en_t layer_decode(input phase_e ph);
    layer_en_t en;
    en = '0;
    case (ph)
      PH_CREDITS: en.text = 1'b1;
      PH_GAME: begin
        en.text   = 1'b1;
        en.cursor = 1'b1;
        en.board  = 1'b1;
      end
      PH_OVER: begin
        en.text  = 1'b1;
        en.board = 1'b1;
      end
      default: en = '0;
    endcase
    return en;
  endfunction

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lt24_scan_counter.sv
// Raster scan counters for the LT24 panel: column/row address of the pixel being
// offered, plus a one-cycle pulse after the last pixel of a frame is accepted.
module lt24_scan_counter #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic       clock,
  input  logic       globalResetn,
  input  logic       pixelReady,
  output logic [7:0] xAddr,
  output logic [8:0] yAddr,
  output logic       frameDone
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  logic [7:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       done_q, done_d;

  // pixelReady is the ready of an always-valid pixel stream: the pixel at
  // (xAddr, yAddr) is taken on every cycle it is high, otherwise the scan holds.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    done_d = 1'b0;
    if (pixelReady) begin
      if (x_q >= X_LAST) begin
        x_d = '0;
        if (y_q >= Y_LAST) begin
          y_d    = '0;
          done_d = 1'b1;
        end else begin
          y_d = y_q + 9'd1;
        end
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!globalResetn) begin
      x_q    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

  assign xAddr     = x_q;
  assign yAddr     = y_q;
  assign frameDone = done_q;

endmodule

// File: rtl/lt24_frame_scheduler.sv
// Screen-phase sequencer for the LT24 pipeline: scan counters, frame counting, click
// capture and the SPLASH -> CREDITS -> GAME <-> OVER flow with its layer enables and pulses.
module lt24_frame_scheduler
  import lt24_sched_pkg::*;
#(
  parameter int WIDTH          = 240,
  parameter int HEIGHT         = 320,
  parameter int SPLASH_FRAMES  = 400,
  parameter int CREDITS_FRAMES = 128,
  parameter int OVER_FRAMES    = 64
) (
  input  logic       clock,
  input  logic       globalResetn,
  input  logic       pixelReady,
  input  logic [1:0] game_state,
  input  logic       mouse_click,
  output logic [7:0] xAddr,
  output logic [8:0] yAddr,
  output logic       frameDone,
  output logic [2:0] phase,
  output logic       textEnable,
  output logic       cursorEnable,
  output logic       boardEnable,
  output logic       newGame,
  output logic       triggerImperialMarch
);

  localparam int              MAX_FRAMES = max_of3(SPLASH_FRAMES, CREDITS_FRAMES, OVER_FRAMES);
  localparam int              CW         = $clog2(MAX_FRAMES) + 1;
  localparam logic [CW-1:0]   CNT_MAX    = '1;

  phase_e        phase_q, phase_d;
  logic [CW-1:0] frame_cnt_q;
  logic          mouse_click_q;
  logic          click_pending_q;
  logic          new_game_q;
  logic          march_q;
  layer_en_t     en_q;

  logic          click_edge;
  logic          discard_click;
  logic          phase_change;
  int            frames_seen;

  lt24_scan_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_scan (
    .clock       (clock),
    .globalResetn(globalResetn),
    .pixelReady  (pixelReady),
    .xAddr       (xAddr),
    .yAddr       (yAddr),
    .frameDone   (frameDone)
  );

  assign click_edge   = mouse_click & ~mouse_click_q;
  assign frames_seen  = int'(frame_cnt_q) + 1;
  assign phase_change = (phase_d != phase_q);

  // Every transition except leaving IDLE is gated by frameDone so a phase never
  // changes in the middle of a frame.
  always_comb begin
    phase_d       = phase_q;
    discard_click = 1'b0;
    case (phase_q)
      PH_IDLE: phase_d = PH_SPLASH;
      PH_SPLASH:
        if (frameDone && (frames_seen >= SPLASH_FRAMES || click_pending_q)) phase_d = PH_CREDITS;
      PH_CREDITS:
        if (frameDone && (frames_seen >= CREDITS_FRAMES || click_pending_q)) phase_d = PH_GAME;
      PH_GAME:
        if (frameDone && (game_state_e'(game_state) != GS_PLAY)) phase_d = PH_OVER;
      PH_OVER:
        if (frameDone) begin
          if (frames_seen >= OVER_FRAMES) begin
            if (click_pending_q) phase_d = PH_GAME;
          end else begin
            discard_click = 1'b1;
          end
        end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!globalResetn) begin
      phase_q         <= PH_IDLE;
      frame_cnt_q     <= '0;
      mouse_click_q   <= 1'b1;
      click_pending_q <= 1'b0;
      new_game_q      <= 1'b0;
      march_q         <= 1'b0;
      en_q            <= '0;
    end else begin
      phase_q       <= phase_d;
      mouse_click_q <= mouse_click;
      march_q       <= (phase_q == PH_IDLE) && (phase_d == PH_SPLASH);
      new_game_q    <= phase_change && (phase_d == PH_GAME);
      en_q          <= layer_decode(phase_d);

      if (phase_change)
        frame_cnt_q <= '0;
      else if (frameDone && frame_cnt_q != CNT_MAX)
        frame_cnt_q <= frame_cnt_q + CW'(1);

      if (phase_change || phase_q == PH_GAME || discard_click)
        click_pending_q <= 1'b0;
      else if (click_edge)
        click_pending_q <= 1'b1;
    end
  end

  assign phase                = phase_q;
  assign textEnable           = en_q.text;
  assign cursorEnable         = en_q.cursor;
  assign boardEnable          = en_q.board;
  assign newGame              = new_game_q;
  assign triggerImperialMarch = march_q;

endmodule

// File: tb/tb_lt24_frame_scheduler.sv
// Bench for lt24_frame_scheduler on a 4x3 raster with short frame budgets: directed
// phase-flow scenarios followed by randomized traffic against a cycle-level reference.
module tb_lt24_frame_scheduler;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int SF   = 2;
  localparam int CF   = 2;
  localparam int OF   = 3;
  localparam int NPIX = W * H;

  logic       clock        = 1'b0;
  logic       globalResetn = 1'b0;
  logic       pixelReady   = 1'b0;
  logic [1:0] game_state   = 2'b00;
  logic       mouse_click  = 1'b0;
  logic [7:0] xAddr;
  logic [8:0] yAddr;
  logic       frameDone;
  logic [2:0] phase;
  logic       textEnable;
  logic       cursorEnable;
  logic       boardEnable;
  logic       newGame;
  logic       triggerImperialMarch;

  int checks = 0;
  int errors = 0;
  int pr_mode = 3;  // 0 always ready, 1 toggle, 2 random, 3 idle

  lt24_frame_scheduler #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .SPLASH_FRAMES (SF),
    .CREDITS_FRAMES(CF),
    .OVER_FRAMES   (OF)
  ) dut (
    .clock               (clock),
    .globalResetn        (globalResetn),
    .pixelReady          (pixelReady),
    .game_state          (game_state),
    .mouse_click         (mouse_click),
    .xAddr               (xAddr),
    .yAddr               (yAddr),
    .frameDone           (frameDone),
    .phase               (phase),
    .textEnable          (textEnable),
    .cursorEnable        (cursorEnable),
    .boardEnable         (boardEnable),
    .newGame             (newGame),
    .triggerImperialMarch(triggerImperialMarch)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_text(input int ph);
    return (ph == 2 || ph == 3 || ph == 4) ? 1 : 0;
  endfunction
  function automatic int exp_cursor(input int ph);
    return (ph == 3) ? 1 : 0;
  endfunction
  function automatic int exp_board(input int ph);
    return (ph == 3 || ph == 4) ? 1 : 0;
  endfunction

  // ---------------- reference model ----------------
  // Scan position is a flat pixel index; a click is pending when its edge cycle is
  // newer than the last event that wipes clicks (phase change, discard, GAME cycle).
  int   cyc = 0;
  bit   m_valid = 1'b0;
  int   m_pix = 0;
  bit   m_fd = 1'b0;
  int   m_phase = 0;
  int   m_frames = 0;
  bit   m_prev_btn = 1'b1;
  int   last_edge = -1;
  int   barrier = 0;
  bit   m_ng = 1'b0;
  bit   m_march = 1'b0;
  int   m_nxt;
  bit   m_pend;
  bit   m_discard;
  logic [2:0] exp_q[$];
  logic [2:0] seen_phase = 3'd0;

  always @(posedge clock) begin
    cyc++;
    if (!globalResetn) begin
      if (m_phase != 0) exp_q.push_back(3'd0);
      m_valid    = 1'b1;
      m_pix      = 0;
      m_fd       = 1'b0;
      m_phase    = 0;
      m_frames   = 0;
      m_prev_btn = 1'b1;
      barrier    = cyc;
      m_ng       = 1'b0;
      m_march    = 1'b0;
    end else begin
      m_nxt     = m_phase;
      m_pend    = (last_edge > barrier);
      m_discard = 1'b0;
      case (m_phase)
        0: m_nxt = 1;
        1: if (m_fd && (m_frames + 1 >= SF || m_pend)) m_nxt = 2;
        2: if (m_fd && (m_frames + 1 >= CF || m_pend)) m_nxt = 3;
        3: if (m_fd && game_state != 2'b00) m_nxt = 4;
        4: if (m_fd) begin
             if (m_frames + 1 >= OF) begin
               if (m_pend) m_nxt = 3;
             end else begin
               m_discard = 1'b1;
             end
           end
        default: m_nxt = 0;
      endcase
      if (mouse_click && !m_prev_btn) last_edge = cyc;
      if (m_nxt != m_phase || m_discard || m_phase == 3) barrier = cyc;
      m_frames = (m_nxt != m_phase) ? 0 : m_frames + int'(m_fd);
      m_ng     = (m_nxt == 3) && (m_phase != 3);
      m_march  = (m_phase == 0) && (m_nxt == 1);
      if (m_nxt != m_phase) exp_q.push_back(3'(m_nxt));
      m_phase  = m_nxt;
      m_fd     = pixelReady && (m_pix == NPIX - 1);
      if (pixelReady) m_pix = (m_pix + 1) % NPIX;
      m_prev_btn = mouse_click;
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clock) begin
    if (m_valid) begin
      chk("xAddr", int'(xAddr), m_pix % W);
      chk("yAddr", int'(yAddr), m_pix / W);
      chk("frameDone", int'(frameDone), int'(m_fd));
      chk("phase", int'(phase), m_phase);
      chk("textEnable", int'(textEnable), exp_text(m_phase));
      chk("cursorEnable", int'(cursorEnable), exp_cursor(m_phase));
      chk("boardEnable", int'(boardEnable), exp_board(m_phase));
      chk("newGame", int'(newGame), int'(m_ng));
      chk("triggerImperialMarch", int'(triggerImperialMarch), int'(m_march));
      if (phase != seen_phase) begin
        if (exp_q.size() == 0) chk("phase_seq", int'(phase), -1);
        else chk("phase_seq", int'(phase), int'(exp_q.pop_front()));
        seen_phase = phase;
      end
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clock) begin
    #2;
    case (pr_mode)
      0: pixelReady = 1'b1;
      1: pixelReady = ~pixelReady;
      2: pixelReady = ($urandom_range(0, 1) == 1);
      default: pixelReady = 1'b0;
    endcase
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_fd(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!frameDone && n < budget);
    if (!frameDone) chk("frameDone_timeout", 0, 1);
  endtask

  task automatic click_pulse();
    mouse_click = 1'b1;
    step(1);
    mouse_click = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // 1: reset, then constant pixelReady through SPLASH
    globalResetn = 1'b0;
    step(3);
    chk("rst_phase", int'(phase), 0);
    chk("rst_xAddr", int'(xAddr), 0);
    chk("rst_march", int'(triggerImperialMarch), 0);
    globalResetn = 1'b1;
    pr_mode = 0;
    step(1);
    chk("idle_to_splash", int'(phase), 1);
    chk("march_pulse", int'(triggerImperialMarch), 1);
    chk("first_accept_x", int'(xAddr), 1);
    step(1);
    chk("march_once", int'(triggerImperialMarch), 0);
    wait_fd(200, n);
    chk("splash_after_fd1", int'(phase), 1);
    wait_fd(200, n);
    chk("fd_gap_const", n, 12);
    step(1);
    chk("splash_to_credits", int'(phase), 2);
    chk("credits_text", int'(textEnable), 1);

    // 2 + 4: toggled pixelReady through CREDITS, then GAME entry
    pr_mode = 1;
    wait_fd(200, n);
    wait_fd(200, n);
    chk("fd_gap_toggle", n, 24);
    chk("credits_until_fd", int'(phase), 2);
    step(1);
    chk("credits_to_game", int'(phase), 3);
    chk("newgame_pulse", int'(newGame), 1);
    chk("game_cursor", int'(cursorEnable), 1);
    chk("game_board", int'(boardEnable), 1);
    chk("game_text", int'(textEnable), 1);
    step(1);
    chk("newgame_once", int'(newGame), 0);
    pr_mode = 0;

    // 5: win mid-frame, OVER click timing
    step(3);
    game_state = 2'b01;
    wait_fd(200, n);
    chk("game_until_fd", int'(phase), 3);
    step(1);
    chk("game_to_over", int'(phase), 4);
    chk("over_cursor", int'(cursorEnable), 0);
    chk("over_board", int'(boardEnable), 1);
    game_state = 2'b00;
    step(3);
    click_pulse();
    wait_fd(200, n);
    step(1);
    chk("over_early_click", int'(phase), 4);
    wait_fd(200, n);
    step(3);
    click_pulse();
    wait_fd(200, n);
    chk("over_until_fd", int'(phase), 4);
    step(1);
    chk("over_to_game", int'(phase), 3);
    chk("over_newgame", int'(newGame), 1);

    // 6: reset mid-frame in GAME with the button held
    step(5);
    mouse_click  = 1'b1;
    globalResetn = 1'b0;
    step(1);
    chk("midrst_x", int'(xAddr), 0);
    chk("midrst_y", int'(yAddr), 0);
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_fd", int'(frameDone), 0);
    chk("midrst_text", int'(textEnable), 0);
    chk("midrst_cursor", int'(cursorEnable), 0);
    chk("midrst_board", int'(boardEnable), 0);
    chk("midrst_newgame", int'(newGame), 0);
    step(1);
    globalResetn = 1'b1;
    wait_fd(200, n);
    step(1);
    chk("held_no_click", int'(phase), 1);
    // 3b: timer expiry and click in the same frame -> one advance
    mouse_click = 1'b0;
    step(2);
    click_pulse();
    wait_fd(200, n);
    step(1);
    chk("single_advance", int'(phase), 2);
    wait_fd(200, n);
    step(1);
    chk("credits_stays", int'(phase), 2);

    // 3a: click mid-frame 1 of SPLASH
    globalResetn = 1'b0;
    step(2);
    globalResetn = 1'b1;
    step(3);
    click_pulse();
    wait_fd(200, n);
    chk("splash_until_fd1", int'(phase), 1);
    step(1);
    chk("click_advance", int'(phase), 2);

    // randomized traffic
    pr_mode = 2;
    repeat (3000) begin
      step(1);
      if ($urandom_range(0, 9) == 0) mouse_click = ~mouse_click;
      if ($urandom_range(0, 59) == 0)
        game_state = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if ($urandom_range(0, 999) == 0) begin
        globalResetn = 1'b0;
        step(2);
        globalResetn = 1'b1;
      end
    end
    @(negedge clock);
    #1;
    chk("phase_seq_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
